// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;
  localparam int DEF_CNT_W      = 4;

  // All-ones at any width once truncated to the quotient width.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
import div_pkg::*;

module div_step #(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   i_r,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_d,
  output logic [DIVISOR_W:0]   o_r,
  output logic                 o_q
);

  logic [DIVISOR_W:0] w_t;
  logic [DIVISOR_W:0] w_diff;
  logic               w_unused_r_msb;

  // R stays below D between steps, so its top bit never carries into T.
  assign w_unused_r_msb = i_r[DIVISOR_W];

  assign w_t    = {i_r[DIVISOR_W-1:0], i_bit};
  assign w_diff = w_t - {1'b0, i_d};
  assign o_q    = (w_t >= {1'b0, i_d});
  assign o_r    = o_q ? w_diff : w_t;

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake.
//
//   state  | meaning
//   IDLE   | waiting for start, results held
//   RUN    | one quotient bit per clock, counter counting down
//   FINISH | Q/R final; published with a done pulse on the next edge
import div_pkg::*;

module sequential_divider #(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  state_t                r_state;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_d;
  logic [DIVISOR_W:0]    r_r;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dbz_pend;

  logic                  w_accept;
  logic                  w_q_bit;
  logic [DIVISOR_W:0]    w_r_next;

  // The busy gate keeps a start in the last RUN-to-FINISH cycle from being taken.
  assign w_accept = start && (r_state != RUN) && !busy;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_div_step (
    .i_r   (r_r),
    .i_bit (r_q[DIVIDEND_W-1]),
    .i_d   (r_d),
    .o_r   (w_r_next),
    .o_q   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_d         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_dbz_pend  <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (r_state == RUN);

      if (r_state == FINISH) begin
        quotient    <= r_q;
        remainder   <= r_r[DIVISOR_W-1:0];
        done        <= 1'b1;
        div_by_zero <= r_dbz_pend;
      end

      case (r_state)
        RUN: begin
          r_q   <= {r_q[DIVIDEND_W-2:0], w_q_bit};
          r_r   <= w_r_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FINISH;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        r_d <= divisor;
        r_r <= '0;
        if (divisor == '0) begin
          r_q        <= DIVIDEND_W'(DBZ_QUOTIENT);
          r_cnt      <= '0;
          r_dbz_pend <= 1'b1;
          r_state    <= FINISH;
        end else begin
          r_q        <= dividend;
          r_cnt      <= CNT_W'(DIVIDEND_W);
          r_dbz_pend <= 1'b0;
          r_state    <= RUN;
          // A flag being published this same edge takes priority.
          if (r_state != FINISH) begin
            div_by_zero <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider against an arithmetic reference.
module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  sequential_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_div(input int dd, input int ds, output int q, output int r);
    if (ds == 0) begin
      q = 255;
      r = 0;
    end else begin
      q = dd / ds;
      r = dd % ds;
    end
  endfunction

  // Called at a negedge; leaves the bench at the negedge just after the start edge.
  task automatic launch(input logic [7:0] dd, input logic [3:0] ds);
    start    = 1'b1;
    dividend = dd;
    divisor  = ds;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  task automatic wait_done(input int k0, output logic [7:0] q, output logic [3:0] r,
                           output logic z, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    q    = 'x;
    r    = 'x;
    z    = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        lat = k0 + k;
        q   = quotient;
        r   = remainder;
        z   = div_by_zero;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [7:0] dd, input logic [3:0] ds, output logic [7:0] q,
                        output logic [3:0] r, output logic z, output int lat, output int bcnt);
    @(negedge clk);
    launch(dd, ds);
    wait_done(0, q, r, z, lat, bcnt);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
    end
    n_tests++;
    if (quotient !== 8'd0 || remainder !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_results: q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat, bcnt;
    run_op(8'd200, 4'd7, q, r, z, lat, bcnt);
    n_tests++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 9", lat);
    end
    n_tests++;
    if (bcnt !== 8) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d expected 8", bcnt);
    end
    n_tests++;
    if (q !== 8'd28 || r !== 4'd4 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b expected 28 4 0", q, r, z);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] dds [4] = '{8'd255, 8'd255, 8'd0, 8'd14};
    logic [3:0] dss [4] = '{4'd1, 4'd15, 4'd5, 4'd15};
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat, bcnt, eq, er;
    for (int i = 0; i < 4; i++) begin
      run_op(dds[i], dss[i], q, r, z, lat, bcnt);
      ref_div(int'(dds[i]), int'(dss[i]), eq, er);
      n_tests++;
      if (int'(q) != eq || int'(r) != er || lat != 9 || z !== 1'b0) begin
        n_fail++;
        $display("FAIL boundary_%0d_%0d: q=%0d r=%0d lat=%0d dbz=%b expected %0d %0d 9 0",
                 dds[i], dss[i], q, r, lat, z, eq, er);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat, bcnt;
    run_op(8'd13, 4'd0, q, r, z, lat, bcnt);
    n_tests++;
    if (lat !== 1 || bcnt !== 0) begin
      n_fail++;
      $display("FAIL dbz_timing: lat=%0d busy_cycles=%0d expected 1 0", lat, bcnt);
    end
    n_tests++;
    if (q !== 8'hFF || r !== 4'd0 || z !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: q=%h r=%0d dbz=%b expected ff 0 1", q, r, z);
    end
    @(negedge clk);
    n_tests++;
    if (div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_hold: dbz=%b expected 1", div_by_zero);
    end
    run_op(8'd10, 4'd3, q, r, z, lat, bcnt);
    n_tests++;
    if (z !== 1'b0 || q !== 8'd3 || r !== 4'd1) begin
      n_fail++;
      $display("FAIL dbz_clear: q=%0d r=%0d dbz=%b expected 3 1 0", q, r, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat, bcnt;
    @(negedge clk);
    launch(8'd100, 4'd3);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd5;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'd77;
    divisor  = 4'd2;
    wait_done(4, q, r, z, lat, bcnt);
    n_tests++;
    if (lat !== 9 || q !== 8'd33 || r !== 4'd1) begin
      n_fail++;
      $display("FAIL ignore_busy_start: lat=%0d q=%0d r=%0d expected 9 33 1", lat, q, r);
    end
    // Start presented in the done cycle; a stray second done would cut the latency short.
    launch(8'd50, 4'd5);
    wait_done(0, q, r, z, lat, bcnt);
    n_tests++;
    if (lat !== 9 || q !== 8'd10 || r !== 4'd0) begin
      n_fail++;
      $display("FAIL back_to_back: lat=%0d q=%0d r=%0d expected 9 10 0", lat, q, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat, bcnt, ndone;
    @(negedge clk);
    launch(8'd180, 4'd11);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b q=%0d r=%0d expected 0 0 0 0",
               busy, done, quotient, remainder);
    end
    rst   = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_tests++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: saw %0d done pulses expected 0", ndone);
    end
    run_op(8'd180, 4'd11, q, r, z, lat, bcnt);
    n_tests++;
    if (lat !== 9 || q !== 8'd16 || r !== 4'd4) begin
      n_fail++;
      $display("FAIL after_reset: lat=%0d q=%0d r=%0d expected 9 16 4", lat, q, r);
    end
  endtask

  task automatic test_random();
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat, bcnt, eq, er, dd, ds;
    for (int i = 0; i < 1000; i++) begin
      dd = int'($urandom_range(0, 255));
      ds = int'($urandom_range(1, 15));
      run_op(8'(dd), 4'(ds), q, r, z, lat, bcnt);
      ref_div(dd, ds, eq, er);
      n_tests++;
      if (int'(q) * ds + int'(r) != dd || int'(r) >= ds || lat != 9) begin
        n_fail++;
        $display("FAIL rand_identity %0d/%0d: q=%0d r=%0d lat=%0d", dd, ds, q, r, lat);
      end
      n_tests++;
      if (int'(q) != eq || int'(r) != er || z !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_model %0d/%0d: q=%0d r=%0d dbz=%b expected %0d %0d 0",
                 dd, ds, q, r, z, eq, er);
      end
      if (eq < 16) begin
        logic [7:0] prod;
        prod = {4'd0, q[3:0]} * {4'd0, 4'(ds)};
        n_tests++;
        if (q[7:4] !== 4'd0 || prod + {4'd0, r} !== 8'(dd)) begin
          n_fail++;
          $display("FAIL rand_mult_xcheck %0d/%0d: q=%0d r=%0d", dd, ds, q, r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
